// File: rtl/disp_scan_mux.sv
// Four-digit multiplexed 7-segment scanner with a per-slot anti-ghosting blank phase.
// New data is staged on load and committed only at frame boundaries, so every frame shows one snapshot.
module disp_scan_mux #(
  parameter int unsigned PRESCALE     = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  blank_mask,
  output logic        ack,
  output logic [1:0]  digit_sel,
  output logic [3:0]  AN,
  output logic [0:6]  D
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST      = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [1:0]    sel_nx;
  logic          wrap, commit;
  logic [15:0]   stage_val, shown_val;
  logic [3:0]    stage_mask, shown_mask;
  logic          pending;
  logic [3:0]    an_nx;
  logic [0:6]    d_nx;
  logic [3:0]    nib;

  function automatic logic [0:6] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'b0000001;
      4'h1: seg7 = 7'b1001111;
      4'h2: seg7 = 7'b0010010;
      4'h3: seg7 = 7'b0000110;
      4'h4: seg7 = 7'b1001100;
      4'h5: seg7 = 7'b0100100;
      4'h6: seg7 = 7'b0100000;
      4'h7: seg7 = 7'b0001111;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0000100;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b1100000;
      4'hC: seg7 = 7'b0110001;
      4'hD: seg7 = 7'b1000010;
      4'hE: seg7 = 7'b0110000;
      default: seg7 = 7'b0111000;
    endcase
  endfunction

  // Outputs are registered from the next-cycle scan position so AN/D line up with cnt without lag.
  always_comb begin
    wrap     = (cnt == LAST);
    commit   = wrap && (digit_sel == 2'd3) && pending;
    cnt_nx   = wrap ? '0 : cnt + CW'(1);
    sel_nx   = wrap ? digit_sel + 2'd1 : digit_sel;
    state_nx = state;
    case (state)
      ST_BLANK: if (cnt_nx == BLANK_END) state_nx = ST_SHOW;
      ST_SHOW:  if (wrap)                state_nx = ST_BLANK;
      default:                           state_nx = ST_BLANK;
    endcase
    nib   = shown_val[{sel_nx, 2'b00} +: 4];
    an_nx = '1;
    d_nx  = '1;
    // The cycle after a commit is always BLANK, so reading the pre-commit snapshot here is safe.
    if (state_nx == ST_SHOW) begin
      an_nx[sel_nx] = 1'b0;
      if (!shown_mask[sel_nx]) d_nx = seg7(nib);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      digit_sel  <= '0;
      state      <= ST_BLANK;
      AN         <= '1;
      D          <= '1;
      ack        <= 1'b0;
      pending    <= 1'b0;
      stage_val  <= '0;
      stage_mask <= '0;
      shown_val  <= '0;
      shown_mask <= '0;
    end else begin
      cnt       <= cnt_nx;
      digit_sel <= sel_nx;
      state     <= state_nx;
      AN        <= an_nx;
      D         <= d_nx;
      ack       <= commit;
      if (load) begin
        stage_val  <= value;
        stage_mask <= blank_mask;
      end
      if (commit) begin
        shown_val  <= stage_val;
        shown_mask <= stage_mask;
      end
      if (load)        pending <= 1'b1;
      else if (commit) pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_disp_scan_mux.sv
// Directed bench for disp_scan_mux (PRESCALE=8, BLANK_CYCLES=2): a queue holds staged display
// snapshots pushed on load and popped at each frame boundary, then every cycle is compared.
module tb_disp_scan_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [15:0] value;
  logic [3:0]  blank_mask;
  logic        ack;
  logic [1:0]  digit_sel;
  logic [3:0]  AN;
  logic [0:6]  D;

  typedef struct {
    logic [15:0] val;
    logic [3:0]  mask;
  } ent_t;

  ent_t        sb[$];
  logic [0:6]  seg_tab [16];
  logic [15:0] disp_val;
  logic [3:0]  disp_mask;
  logic        exp_ack;
  int unsigned t;
  int          checks = 0;
  int          errors = 0;

  disp_scan_mux #(.PRESCALE(8), .BLANK_CYCLES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .value      (value),
    .blank_mask (blank_mask),
    .ack        (ack),
    .digit_sel  (digit_sel),
    .AN         (AN),
    .D          (D)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s t=%0d got %h exp %h", tag, t, got, exp);
    end
  endtask

  task automatic check_outputs();
    int unsigned c, s;
    logic [3:0]  exp_an;
    logic [0:6]  exp_d;
    logic [3:0]  nib;
    c = t % 8;
    s = (t / 8) % 4;
    exp_an = 4'hF;
    exp_d  = 7'b1111111;
    if (c >= 2) begin
      exp_an[s] = 1'b0;
      nib = disp_val[4*s +: 4];
      if (!disp_mask[s]) exp_d = seg_tab[nib];
    end
    chk("an",  {4'h0, AN},            {4'h0, exp_an});
    chk("d",   {1'b0, D},             {1'b0, exp_d});
    chk("sel", {6'h0, digit_sel},     {6'h0, 2'(s)});
    chk("ack", {7'h0, ack},           {7'h0, exp_ack});
  endtask

  task automatic tick();
    ent_t e;
    @(posedge clk);
    t++;
    exp_ack = 1'b0;
    if ((t % 32 == 0) && (sb.size() > 0)) begin
      disp_val  = sb[0].val;
      disp_mask = sb[0].mask;
      void'(sb.pop_front());
      exp_ack = 1'b1;
    end
    if (load) begin
      e.val  = value;
      e.mask = blank_mask;
      if (sb.size() == 0) sb.push_back(e);
      else sb[sb.size()-1] = e;
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic run_to(input int unsigned pos);
    for (int unsigned i = 0; i < 64 && (t % 32) != pos; i++) tick();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] m);
    load = 1'b1; value = v; blank_mask = m;
    tick();
    load = 1'b0; value = 16'h0000; blank_mask = 4'h0;
  endtask

  task automatic model_reset();
    sb.delete();
    disp_val  = 16'h0000;
    disp_mask = 4'h0;
    exp_ack   = 1'b0;
    t         = 0;
  endtask

  initial begin
    seg_tab[0]  = 7'b0000001; seg_tab[1]  = 7'b1001111;
    seg_tab[2]  = 7'b0010010; seg_tab[3]  = 7'b0000110;
    seg_tab[4]  = 7'b1001100; seg_tab[5]  = 7'b0100100;
    seg_tab[6]  = 7'b0100000; seg_tab[7]  = 7'b0001111;
    seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0000100;
    seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b1100000;
    seg_tab[12] = 7'b0110001; seg_tab[13] = 7'b1000010;
    seg_tab[14] = 7'b0110000; seg_tab[15] = 7'b0111000;

    rst_n = 1'b0; load = 1'b0; value = 16'h0000; blank_mask = 4'h0;
    model_reset();
    #12;
    chk("rst_an",  {4'h0, AN},        8'h0F);
    chk("rst_d",   {1'b0, D},         8'h7F);
    chk("rst_ack", {7'h0, ack},       8'h00);
    chk("rst_sel", {6'h0, digit_sel}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    check_outputs();

    // Idle scan: two full frames of zeros.
    run(64);

    // Load during digit 1; shown only after the frame boundary.
    run_to(10);
    do_load(16'h8A3F, 4'h0);
    run_to(0);
    run(32);

    // Two loads in one frame: latest wins, single ack.
    run_to(5);
    do_load(16'h1111, 4'h0);
    run_to(20);
    do_load(16'h2222, 4'h0);
    run_to(0);
    run(32);

    // Masked load, then a load that lands exactly on the commit edge.
    run_to(10);
    do_load(16'h4321, 4'b1010);
    run_to(31);
    do_load(16'hBCDE, 4'h0);
    run(31);
    run(33);

    // Async reset during SHOW of digit 2 with data pending.
    run_to(5);
    do_load(16'h9999, 4'h0);
    run_to(20);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_an",  {4'h0, AN},        8'h0F);
    chk("arst_d",   {1'b0, D},         8'h7F);
    chk("arst_ack", {7'h0, ack},       8'h00);
    chk("arst_sel", {6'h0, digit_sel}, 8'h00);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    check_outputs();
    run(70);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
